// File: rtl/hiscore_pkg.sv
// Shared types and default widths for the hiscore engine and its work-RAM arbiter.
package hiscore_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PAUSE_WAIT = 2'd1,
    GRANT      = 2'd2,
    COOLDOWN   = 2'd3
  } hs_arb_state_t;

  localparam int HS_ADDR_W = 10;
  localparam int HS_DATA_W = 8;

endpackage

// File: rtl/hiscore_ram_arbiter.sv
// Time-shares the single-port work RAM between the CPU and the hiscore engine,
// pausing the CPU for bounded engine bursts separated by a guaranteed CPU run gap.
//
// state      | meaning
// IDLE       | CPU owns RAM, waiting for hs_req
// PAUSE_WAIT | CPU paused, waiting for cpu_halted or settle timeout
// GRANT      | engine owns RAM, one access per cycle up to MAX_BURST
// COOLDOWN   | CPU owns RAM again for CPU_GAP cycles
module hiscore_ram_arbiter
  import hiscore_pkg::*;
#(
  parameter int ADDR_W     = HS_ADDR_W,
  parameter int DATA_W     = HS_DATA_W,
  parameter int MAX_BURST  = 16,
  parameter int CPU_GAP    = 8,
  parameter int SETTLE_MAX = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_halted,
  output logic              cpu_pause,
  input  logic              hs_req,
  input  logic              hs_we,
  input  logic [ADDR_W-1:0] hs_addr,
  input  logic [DATA_W-1:0] hs_wdata,
  output logic              hs_grant,
  output logic              hs_rvalid,
  output logic [DATA_W-1:0] hs_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              settle_timeout
);

  localparam int BURST_W  = $clog2(MAX_BURST + 1);
  localparam int SETTLE_W = $clog2(SETTLE_MAX + 1);
  localparam int GAP_W    = $clog2(CPU_GAP + 1);

  localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(MAX_BURST - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_MAX - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(CPU_GAP - 1);

  hs_arb_state_t     state;
  logic [BURST_W-1:0]  burst_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DATA_W-1:0]   rdata_hold;
  logic                eng_owns;

  assign eng_owns  = (state == GRANT);
  assign hs_grant  = eng_owns & hs_req;
  assign ram_addr  = eng_owns ? hs_addr  : cpu_addr;
  assign ram_wdata = eng_owns ? hs_wdata : cpu_wdata;
  assign ram_we    = eng_owns ? (hs_req & hs_we) : cpu_we;

  // ram_q is only valid in the cycle after the address, so pass it through
  // while hs_rvalid is high and hold the last value otherwise.
  assign hs_rdata  = hs_rvalid ? ram_q : rdata_hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cpu_pause      <= 1'b0;
      hs_rvalid      <= 1'b0;
      rdata_hold     <= '0;
      settle_timeout <= 1'b0;
      burst_cnt      <= '0;
      settle_cnt     <= '0;
      gap_cnt        <= '0;
    end else begin
      hs_rvalid <= hs_grant & ~hs_we;
      if (hs_rvalid) rdata_hold <= ram_q;

      case (state)
        IDLE: begin
          if (hs_req) begin
            state      <= PAUSE_WAIT;
            cpu_pause  <= 1'b1;
            settle_cnt <= '0;
          end
        end

        PAUSE_WAIT: begin
          // An abort beats a simultaneous halt acknowledge.
          if (!hs_req) begin
            state     <= COOLDOWN;
            cpu_pause <= 1'b0;
            gap_cnt   <= '0;
          end else if (cpu_halted) begin
            state     <= GRANT;
            burst_cnt <= '0;
          end else if (settle_cnt >= SETTLE_LAST) begin
            state          <= GRANT;
            burst_cnt      <= '0;
            settle_timeout <= 1'b1;
          end else if (settle_cnt != '1) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        GRANT: begin
          if (hs_req && burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
          if (!hs_req || burst_cnt >= BURST_LAST) begin
            state     <= COOLDOWN;
            cpu_pause <= 1'b0;
            gap_cnt   <= '0;
          end
        end

        COOLDOWN: begin
          if (gap_cnt >= GAP_LAST) begin
            state <= IDLE;
          end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          cpu_pause <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed-step bench for hiscore_ram_arbiter with a synchronous RAM model.
module tb_hiscore_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       cpu_halted;
  logic       cpu_pause;
  logic       hs_req;
  logic       hs_we;
  logic [9:0] hs_addr;
  logic [7:0] hs_wdata;
  logic       hs_grant;
  logic       hs_rvalid;
  logic [7:0] hs_rdata;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_q;
  logic       settle_timeout;

  logic [7:0] mem [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  hiscore_ram_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_we         (cpu_we),
    .cpu_halted     (cpu_halted),
    .cpu_pause      (cpu_pause),
    .hs_req         (hs_req),
    .hs_we          (hs_we),
    .hs_addr        (hs_addr),
    .hs_wdata       (hs_wdata),
    .hs_grant       (hs_grant),
    .hs_rvalid      (hs_rvalid),
    .hs_rdata       (hs_rdata),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_q          (ram_q),
    .settle_timeout (settle_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    hs_req  = 1'b0;
    cpu_we  = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] rv [3];
    int ng;
    rv[0] = 8'h0F; rv[1] = 8'h04; rv[2] = 8'h12;

    reset_n    = 1'b0;
    cpu_addr   = 10'h155;
    cpu_wdata  = 8'h00;
    cpu_we     = 1'b0;
    cpu_halted = 1'b0;
    hs_req     = 1'b0;
    hs_we      = 1'b0;
    hs_addr    = '0;
    hs_wdata   = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst_pause",   32'(cpu_pause), 0);
    chk("rst_grant",   32'(hs_grant), 0);
    chk("rst_rvalid",  32'(hs_rvalid), 0);
    chk("rst_rdata",   32'(hs_rdata), 0);
    chk("rst_timeout", 32'(settle_timeout), 0);
    chk("rst_mux",     32'(ram_addr), 32'h155);

    // Basic write burst
    do_reset();
    cpu_halted = 1'b1; hs_we = 1'b1; hs_req = 1'b1;
    hs_addr = 10'h00B; hs_wdata = 8'h10;
    #1 chk("wr_c0_grant", 32'(hs_grant), 0);
    tick(); #1;
    chk("wr_c1_pause", 32'(cpu_pause), 1);
    chk("wr_c1_grant", 32'(hs_grant), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      hs_addr = 10'(11 + k); hs_wdata = 8'(16 + k);
      #1;
      chk($sformatf("wr_grant_%0d", k), 32'(hs_grant), 1);
      chk($sformatf("wr_we_%0d", k),    32'(ram_we), 1);
      chk($sformatf("wr_addr_%0d", k),  32'(ram_addr), 32'(11 + k));
    end
    tick(); hs_req = 1'b0; #1;
    chk("wr_drop_grant", 32'(hs_grant), 0);
    chk("wr_drop_we",    32'(ram_we), 0);
    tick(); #1;
    chk("wr_cool_pause", 32'(cpu_pause), 0);
    for (int k = 0; k < 4; k++) chk($sformatf("wr_mem_%0d", k), 32'(mem[11 + k]), 32'(16 + k));
    hs_req = 1'b1;
    for (int c = 8; c <= 15; c++) begin
      tick(); #1;
      chk($sformatf("wr_gap_pause_c%0d", c), 32'(cpu_pause), 0);
    end
    tick(); #1;
    chk("wr_repause", 32'(cpu_pause), 1);

    // Read burst, RAM preloaded through the CPU path
    do_reset();
    cpu_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cpu_addr = 10'(35 + k); cpu_wdata = rv[k];
      tick();
    end
    cpu_we = 1'b0; cpu_addr = 10'h155;
    hs_we = 1'b0; hs_req = 1'b1; hs_addr = 10'h023;
    tick();
    tick(); #1;
    chk("rd_c2_grant",  32'(hs_grant), 1);
    chk("rd_c2_rvalid", 32'(hs_rvalid), 0);
    tick(); hs_addr = 10'h024; #1;
    chk("rd_c3_rvalid", 32'(hs_rvalid), 1);
    chk("rd_c3_rdata",  32'(hs_rdata), 32'h0F);
    tick(); hs_addr = 10'h025; #1;
    chk("rd_c4_rvalid", 32'(hs_rvalid), 1);
    chk("rd_c4_rdata",  32'(hs_rdata), 32'h04);
    tick(); hs_req = 1'b0; #1;
    chk("rd_c5_grant",  32'(hs_grant), 0);
    chk("rd_c5_rvalid", 32'(hs_rvalid), 1);
    chk("rd_c5_rdata",  32'(hs_rdata), 32'h12);
    tick(); #1;
    chk("rd_c6_rvalid", 32'(hs_rvalid), 0);
    chk("rd_c6_pause",  32'(cpu_pause), 0);

    // Burst cap with the CPU still trying to write
    do_reset();
    cpu_halted = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'hAA;
    hs_we = 1'b1; hs_req = 1'b1;
    ng = 0;
    for (int c = 0; c < 40; c++) begin
      logic eg, ep;
      hs_addr = 10'(256 + c); hs_wdata = 8'(c);
      eg = (c >= 2 && c <= 17) || (c >= 28);
      ep = (c >= 1 && c <= 17) || (c >= 27);
      #1;
      chk($sformatf("cap_grant_c%0d", c), 32'(hs_grant), 32'(eg));
      chk($sformatf("cap_pause_c%0d", c), 32'(cpu_pause), 32'(ep));
      if (eg) begin
        chk($sformatf("cap_addr_c%0d", c),  32'(ram_addr), 32'(256 + c));
        chk($sformatf("cap_wdata_c%0d", c), 32'(ram_wdata), 32'(c));
      end else begin
        chk($sformatf("cap_cpuaddr_c%0d", c), 32'(ram_addr), 32'h3FF);
      end
      if (hs_grant) ng++;
      tick();
    end
    chk("cap_total_grants", 32'(ng), 28);

    // Settle timeout
    do_reset();
    cpu_we = 1'b0; cpu_addr = 10'h155;
    cpu_halted = 1'b0; hs_req = 1'b1; hs_we = 1'b1; hs_addr = 10'h040; hs_wdata = 8'h55;
    for (int c = 0; c <= 32; c++) begin
      #1;
      chk($sformatf("to_grant_c%0d", c), 32'(hs_grant), 0);
      if (c == 32) chk("to_flag_c32", 32'(settle_timeout), 0);
      tick();
    end
    #1;
    chk("to_grant_c33", 32'(hs_grant), 1);
    chk("to_flag_c33",  32'(settle_timeout), 1);
    tick(); hs_req = 1'b0;
    tick(); #1;
    chk("to_cool_pause", 32'(cpu_pause), 0);
    chk("to_flag_cool",  32'(settle_timeout), 1);
    chk("to_mem",        32'(mem[64]), 32'h55);
    repeat (10) tick();
    chk("to_flag_late", 32'(settle_timeout), 1);

    // Abort on the 3rd PAUSE_WAIT cycle, with cpu_halted rising at the same time
    do_reset();
    cpu_halted = 1'b0; hs_req = 1'b1; hs_we = 1'b1;
    #1 chk("ab_c0_grant", 32'(hs_grant), 0);
    tick(); #1 chk("ab_c1_pause", 32'(cpu_pause), 1);
    tick(); #1 chk("ab_c2_grant", 32'(hs_grant), 0);
    tick(); hs_req = 1'b0; cpu_halted = 1'b1; #1;
    chk("ab_c3_grant", 32'(hs_grant), 0);
    tick(); #1;
    chk("ab_c4_pause", 32'(cpu_pause), 0);
    chk("ab_c4_grant", 32'(hs_grant), 0);
    hs_req = 1'b1;
    for (int c = 5; c <= 12; c++) begin
      tick(); #1;
      chk($sformatf("ab_pause_c%0d", c), 32'(cpu_pause), 0);
      chk($sformatf("ab_grant_c%0d", c), 32'(hs_grant), 0);
    end
    tick(); #1 chk("ab_c13_pause", 32'(cpu_pause), 1);
    tick(); #1 chk("ab_c14_grant", 32'(hs_grant), 1);
    chk("ab_timeout", 32'(settle_timeout), 0);

    // Reset in the cycle after a granted read
    do_reset();
    cpu_halted = 1'b1; hs_we = 1'b0; hs_addr = 10'h023; hs_req = 1'b1; cpu_addr = 10'h2AA;
    tick();
    tick(); #1 chk("rm_c2_grant", 32'(hs_grant), 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("rm_rvalid", 32'(hs_rvalid), 0);
    chk("rm_pause",  32'(cpu_pause), 0);
    chk("rm_grant",  32'(hs_grant), 0);
    chk("rm_mux",    32'(ram_addr), 32'h2AA);
    tick();
    reset_n = 1'b1;
    #1 chk("rm_r0_pause", 32'(cpu_pause), 0);
    tick(); #1 chk("rm_r1_pause", 32'(cpu_pause), 1);
    tick(); #1;
    chk("rm_r2_grant", 32'(hs_grant), 1);
    chk("rm_r2_addr",  32'(ram_addr), 32'h023);
    tick(); hs_req = 1'b0; #1;
    chk("rm_r3_rvalid", 32'(hs_rvalid), 1);
    chk("rm_r3_rdata",  32'(hs_rdata), 32'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
